pbch_re_demux: RTL

Downstream of the BWP extractor: takes its 240-subcarrier bandwidth-part stream and keeps only symbols whose PBCH flag (tuser bit 0) is set. It splits those resource elements into a PBCH DM-RS stream (every 4th subcarrier, offset v = N_id mod 4) and a PBCH data stream. Each stream is buffered in its own FIFO with AXI-stream backpressure toward the channel estimator and the demapper.

---
 rtl/pbch_pkg.sv | 25 ++
 rtl/axis_fifo.sv | 47 ++++
 rtl/pbch_re_demux.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/pbch_pkg.sv
// Shared widths, per-symbol RE counts and tuser field positions for the PBCH RE demultiplexer.
package pbch_pkg;
    localparam int SFN_WIDTH             = 10;
    localparam int SUBFRAME_NUMBER_WIDTH = 5;
    localparam int SYMBOL_NUMBER_WIDTH   = 4;

    localparam int PBCH_RE_PER_SYM = 240;
    localparam int DMRS_PER_SYM    = 60;
    localparam int DATA_PER_SYM    = 180;

    localparam int DMRS_IDX_W = 6;
    localparam int DATA_IDX_W = 8;

    localparam int TUSER_PBCH_FLAG_POS = 0;
    localparam int TUSER_BLK_EXP_POS   = 1;

    // Symbol, subframe and SFN sit above blk_exp, so their offsets follow its width.
    function automatic int tuser_sym_pos(input int blk_exp_len);
        return TUSER_BLK_EXP_POS + blk_exp_len;
    endfunction

    function automatic int tuser_sfn_pos(input int blk_exp_len);
        return tuser_sym_pos(blk_exp_len) + SYMBOL_NUMBER_WIDTH + SUBFRAME_NUMBER_WIDTH;
    endfunction
endpackage

// File: rtl/axis_fifo.sv
// Synchronous first-word-fall-through FIFO with an AXI-stream read side and a full flag.
// A write while full is taken only if a read frees the slot in the same cycle.
module axis_fifo #(
    parameter int  WIDTH = 8,
    parameter int  DEPTH = 256,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_en,
    output logic             full,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    input  logic             rd_ready
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             empty;
    logic             rd_en;
    logic             wr_ok;

    always_comb begin
        empty = (wr_ptr == rd_ptr);
        full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        rd_en = !empty && rd_ready;
        wr_ok = wr_en && (!full || rd_en);
    end

    assign rd_valid = !empty;
    assign rd_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
    end
endmodule

// File: rtl/pbch_re_demux.sv
// Keeps PBCH-flagged symbols of the 240-RE BWP stream and splits them into DM-RS
// (every 4th RE from offset N_id mod 4) and data streams, each behind its own FIFO.
module pbch_re_demux
    import pbch_pkg::*;
#(
    parameter int  IN_DW               = 16,
    parameter int  BLK_EXP_LEN         = 8,
    parameter int  FIFO_DEPTH          = 256,
    localparam int USER_WIDTH_IN       = SFN_WIDTH + SUBFRAME_NUMBER_WIDTH + SYMBOL_NUMBER_WIDTH + BLK_EXP_LEN + 1,
    localparam int USER_WIDTH_OUT      = USER_WIDTH_IN - 1 + DMRS_IDX_W,
    localparam int USER_WIDTH_OUT_DATA = USER_WIDTH_IN - 1 + DATA_IDX_W
) (
    input  logic                           clk_i,
    input  logic                           reset_ni,
    input  logic [IN_DW-1:0]               s_axis_in_tdata,
    input  logic [USER_WIDTH_IN-1:0]       s_axis_in_tuser,
    input  logic                           s_axis_in_tlast,
    input  logic                           s_axis_in_tvalid,
    input  logic [9:0]                     N_id_i,
    input  logic                           N_id_valid_i,
    output logic [IN_DW-1:0]               m_axis_dmrs_tdata,
    output logic [USER_WIDTH_OUT-1:0]      m_axis_dmrs_tuser,
    output logic                           m_axis_dmrs_tlast,
    output logic                           m_axis_dmrs_tvalid,
    input  logic                           m_axis_dmrs_tready,
    output logic [IN_DW-1:0]               m_axis_data_tdata,
    output logic [USER_WIDTH_OUT_DATA-1:0] m_axis_data_tuser,
    output logic                           m_axis_data_tlast,
    output logic                           m_axis_data_tvalid,
    input  logic                           m_axis_data_tready,
    output logic                           overflow_o,
    output logic                           length_err_o
);
    localparam int DMRS_WORD_W = 1 + USER_WIDTH_OUT + IN_DW;
    localparam int DATA_WORD_W = 1 + USER_WIDTH_OUT_DATA + IN_DW;

    logic                     vld_p0;
    logic                     tlast_p0;
    logic                     nid_vld_p0;
    logic [1:0]               nid_mod4_p0;
    logic [IN_DW-1:0]         tdata_p0;
    logic [USER_WIDTH_IN-1:0] tuser_p0;
    logic                     unused_nid;

    assign unused_nid = ^N_id_i[9:2];

    // Stage p0: input register; only valid/tlast carry reset.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            vld_p0   <= 1'b0;
            tlast_p0 <= 1'b0;
        end else begin
            vld_p0   <= s_axis_in_tvalid;
            tlast_p0 <= s_axis_in_tlast;
        end
    end

    always_ff @(posedge clk_i) begin
        tdata_p0    <= s_axis_in_tdata;
        tuser_p0    <= s_axis_in_tuser;
        nid_mod4_p0 <= N_id_i[1:0];
        nid_vld_p0  <= N_id_valid_i;
    end

    logic [7:0]            re_cnt;
    logic [DMRS_IDX_W-1:0] dmrs_cnt;
    logic [DATA_IDX_W-1:0] data_cnt;
    logic                  accept_q;
    logic [1:0]            v_q;
    logic                  sof, overrun, last_re, acc_cur, is_dmrs;
    logic [1:0]            v_cur;
    logic                  dmrs_wr, data_wr, err_short, err_long, dmrs_last, data_last;
    logic                  dmrs_full, data_full, dmrs_drop, data_drop;

    // Stage p0 -> p1: symbol tracking and routing decide what is written into each FIFO.
    always_comb begin
        sof       = (re_cnt == '0);
        overrun   = (re_cnt == 8'(PBCH_RE_PER_SYM));
        last_re   = (re_cnt == 8'(PBCH_RE_PER_SYM - 1));
        acc_cur   = sof ? (tuser_p0[TUSER_PBCH_FLAG_POS] && nid_vld_p0) : accept_q;
        v_cur     = sof ? nid_mod4_p0 : v_q;
        is_dmrs   = (re_cnt[1:0] == v_cur);
        dmrs_wr   = vld_p0 && acc_cur && !overrun && is_dmrs;
        data_wr   = vld_p0 && acc_cur && !overrun && !is_dmrs;
        // An early tlast or a counter running past the last RE is a framing error;
        // once overrun, the stray tail up to tlast is dropped without a second pulse.
        err_short = vld_p0 && tlast_p0 && !overrun && !last_re;
        err_long  = vld_p0 && !tlast_p0 && last_re;
        dmrs_last = (dmrs_cnt == DMRS_IDX_W'(DMRS_PER_SYM - 1)) && !err_short;
        data_last = (data_cnt == DATA_IDX_W'(DATA_PER_SYM - 1)) && !err_short;
        dmrs_drop = dmrs_wr && dmrs_full && !(m_axis_dmrs_tvalid && m_axis_dmrs_tready);
        data_drop = data_wr && data_full && !(m_axis_data_tvalid && m_axis_data_tready);
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            re_cnt       <= '0;
            dmrs_cnt     <= '0;
            data_cnt     <= '0;
            accept_q     <= 1'b0;
            v_q          <= '0;
            length_err_o <= 1'b0;
            overflow_o   <= 1'b0;
        end else begin
            length_err_o <= err_short || err_long;
            overflow_o   <= overflow_o || dmrs_drop || data_drop;
            if (vld_p0) begin
                if (sof) begin
                    accept_q <= acc_cur;
                    v_q      <= v_cur;
                end
                if (tlast_p0) begin
                    re_cnt   <= '0;
                    dmrs_cnt <= '0;
                    data_cnt <= '0;
                end else if (!overrun) begin
                    re_cnt <= re_cnt + 8'd1;
                    if (dmrs_wr) dmrs_cnt <= dmrs_cnt + 1'b1;
                    if (data_wr) data_cnt <= data_cnt + 1'b1;
                end
            end
        end
    end

    // Stage p1: FIFO write; FWFT read side drives the outputs.
    axis_fifo #(.WIDTH(DMRS_WORD_W), .DEPTH(FIFO_DEPTH)) u_dmrs_fifo (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .wr_data  ({dmrs_last, tuser_p0[USER_WIDTH_IN-1:1], dmrs_cnt, tdata_p0}),
        .wr_en    (dmrs_wr),
        .full     (dmrs_full),
        .rd_data  ({m_axis_dmrs_tlast, m_axis_dmrs_tuser, m_axis_dmrs_tdata}),
        .rd_valid (m_axis_dmrs_tvalid),
        .rd_ready (m_axis_dmrs_tready)
    );

    axis_fifo #(.WIDTH(DATA_WORD_W), .DEPTH(FIFO_DEPTH)) u_data_fifo (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .wr_data  ({data_last, tuser_p0[USER_WIDTH_IN-1:1], data_cnt, tdata_p0}),
        .wr_en    (data_wr),
        .full     (data_full),
        .rd_data  ({m_axis_data_tlast, m_axis_data_tuser, m_axis_data_tdata}),
        .rd_valid (m_axis_data_tvalid),
        .rd_ready (m_axis_data_tready)
    );
endmodule
